// File: rtl/alu_arbiter.sv
// alu_arbiter
// -----------
// Shares one fixed-latency ALU between two requesters. One operation is in
// flight at a time: it is accepted in IDLE, issued to the ALU from registers,
// the ALU latency is waited out in EXEC, and the captured result is offered
// back to the granted requester in RESP.
//
// Handshake rule (used on every request and response channel):
//   a transfer happens on a rising clk edge where valid and ready are both 1.
//   The sender holds valid and payload stable until that edge. ready may
//   depend combinationally on valid.
//
// Arbitration: round-robin by default. The winner on a tie is the requester
// that did not win last time. After reset, requester 0 wins the first tie.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead. In that build
// requester 0 always wins a tie. last_grant is still tracked but is not used.
//
// Ports
//   clk, resetn               clock and synchronous active-low reset
//   reqN_valid/ready          request handshake for requester N (0/1)
//   reqN_ctrl, reqN_a, reqN_b opcode and operands from requester N
//   rspN_valid/ready          response handshake for requester N
//   rspN_result               result for requester N (holds after handshake)
//   alu_ctrl, alu_a, alu_b    registered inputs to the shared ALU
//   alu_y                     ALU result, valid ALU_LATENCY cycles after inputs
//   busy                      1 in every state except IDLE
//   dbg_state_o               current FSM state (IDLE=0, EXEC=1, RESP=2)
module alu_arbiter #(
    parameter int ALU_LATENCY = 1,
    parameter int DATA_W      = 16,
    parameter int CTRL_W      = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;

    logic              any_valid;
    logic              win;

    // Winner selection. With only one requester valid, that requester wins
    // in both builds.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_grant_q;
`endif
        end else begin
            win = req1_valid;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ready is gated by resetn so that no transfer is signalled
                // on an edge where the registers are being reset.
                if (any_valid && resetn) begin
                    req0_ready   = ~win;
                    req1_ready   = win;
                    alu_ctrl_d   = win ? req1_ctrl : req0_ctrl;
                    alu_a_d      = win ? req1_a    : req0_a;
                    alu_b_d      = win ? req1_b    : req0_b;
                    grant_d      = win;
                    last_grant_d = win;
                    cnt_d        = LAT;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Loading LAT and counting down to 0 makes EXEC last LAT+1
                // cycles. alu_y has been valid for at least one cycle by the
                // time it is sampled.
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    if (grant_q) rsp1_result_d = alu_y;
                    else         rsp0_result_d = alu_y;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                if (grant_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            alu_ctrl_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
        end
    end

    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. u_dut uses ALU_LATENCY=1 and u_dut2 uses
// ALU_LATENCY=2. Each one is fed by a small behavioural ALU with the
// matching pipeline depth.
module tb_alu_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT2 = 2;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_NEG = 4'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // ---------------- DUT 1 signals (latency 1) ----------------
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_ctrl [2];
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic [15:0] rsp_result [2];
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        busy;
    logic [1:0]  dbg_state;

    // ---------------- DUT 2 signals (latency 2) ----------------
    logic        d2_resetn;
    logic        d2_req0_valid, d2_req0_ready, d2_rsp0_valid, d2_rsp0_ready;
    logic        d2_req1_valid, d2_req1_ready, d2_rsp1_valid, d2_rsp1_ready;
    logic [3:0]  d2_req0_ctrl, d2_req1_ctrl, d2_alu_ctrl;
    logic [15:0] d2_req0_a, d2_req0_b, d2_req1_a, d2_req1_b;
    logic [15:0] d2_rsp0_result, d2_rsp1_result, d2_alu_a, d2_alu_b, d2_alu_y;
    logic        d2_busy;
    logic [1:0]  d2_dbg_state;

    alu_arbiter #(.ALU_LATENCY(LAT1), .DATA_W(16), .CTRL_W(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
        .req0_ctrl(req_ctrl[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
        .rsp0_result(rsp_result[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
        .req1_ctrl(req_ctrl[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
        .rsp1_result(rsp_result[1]),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    alu_arbiter #(.ALU_LATENCY(LAT2), .DATA_W(16), .CTRL_W(4)) u_dut2 (
        .clk(clk), .resetn(d2_resetn),
        .req0_valid(d2_req0_valid), .req0_ready(d2_req0_ready),
        .req0_ctrl(d2_req0_ctrl), .req0_a(d2_req0_a), .req0_b(d2_req0_b),
        .rsp0_valid(d2_rsp0_valid), .rsp0_ready(d2_rsp0_ready),
        .rsp0_result(d2_rsp0_result),
        .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready),
        .req1_ctrl(d2_req1_ctrl), .req1_a(d2_req1_a), .req1_b(d2_req1_b),
        .rsp1_valid(d2_rsp1_valid), .rsp1_ready(d2_rsp1_ready),
        .rsp1_result(d2_rsp1_result),
        .alu_ctrl(d2_alu_ctrl), .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_y(d2_alu_y),
        .busy(d2_busy), .dbg_state_o(d2_dbg_state)
    );

    // ---------------- behavioural ALUs ----------------
    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
        case (c)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_MUL:  alu_f = a * b;
            OP_NEG:  alu_f = 16'd0 - a;
            default: alu_f = 16'd0;
        endcase
    endfunction

    logic [15:0] y1_q, y2a_q, y2b_q;
    always_ff @(posedge clk) begin
        y1_q  <= alu_f(alu_ctrl, alu_a, alu_b);
        y2a_q <= alu_f(d2_alu_ctrl, d2_alu_a, d2_alu_b);
        y2b_q <= y2a_q;
    end
    assign alu_y    = y1_q;
    assign d2_alu_y = y2b_q;

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one op on DUT 1 ----------------
    // Drives one operation from port p. It checks same-cycle ready, the
    // response latency and the result. The response is held off for bp
    // cycles and stability is checked during that time. The task ends at the
    // negedge after the response handshake.
    task automatic run_op(input int p, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp, input int bp);
        int n;
        bit seen, other_seen;
        logic [15:0] exp_v;
        @(negedge clk);
        req_ctrl[p] = c; req_a[p] = a; req_b[p] = b;
        req_valid[p] = 1'b1;
        rsp_ready[p] = (bp == 0);
        #1;
        check("ready_same_cycle", {31'd0, req_ready[p]}, 32'd1);
        check("other_ready_low", {31'd0, req_ready[1-p]}, 32'd0);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        n = 0; seen = 0; other_seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
            if (rsp_valid[1-p]) other_seen = 1;
            if (rsp_valid[p]) seen = 1;
        end
        check("rsp_latency", n, LAT1 + 2);
        check("other_rsp_never", {31'd0, other_seen}, 32'd0);
        exp_v = exp_q.pop_front();
        check("rsp_result", {16'd0, rsp_result[p]}, {16'd0, exp_v});
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, rsp_valid[p]}, 32'd1);
            check("bp_result_hold", {16'd0, rsp_result[p]}, {16'd0, exp_v});
        end
        rsp_ready[p] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", {31'd0, rsp_valid[p]}, 32'd0);
        check("busy_low_after_rsp", {31'd0, busy}, 32'd0);
        check("result_holds", {16'd0, rsp_result[p]}, {16'd0, exp_v});
        rsp_ready[p] = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          port;
        logic [3:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          bp;
    } vec_t;
    vec_t vecs [5];

    int          order_exp [3];
    logic [15:0] res_exp [2];

    initial begin
        int n, g, pulses;

        vecs[0] = '{0, OP_ADD, 16'h00F0, 16'h000F, 16'h00FF, 0};
        vecs[1] = '{1, OP_SUB, 16'h0100, 16'h000F, 16'h00F1, 0};
        vecs[2] = '{0, OP_NEG, 16'h0001, 16'h0000, 16'hFFFF, 2};
        vecs[3] = '{1, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1};
        vecs[4] = '{0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 0};

        req_valid = 2'b00; rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_ctrl[i] = 4'd0; req_a[i] = 16'd0; req_b[i] = 16'd0;
        end
        d2_resetn = 1'b0;
        d2_req0_valid = 0; d2_req1_valid = 0; d2_rsp0_ready = 0; d2_rsp1_ready = 0;
        d2_req0_ctrl = 0; d2_req0_a = 0; d2_req0_b = 0;
        d2_req1_ctrl = 0; d2_req1_a = 0; d2_req1_b = 0;

        // Reset with both requesters valid. No ready may be raised.
        resetn = 1'b0;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {30'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        check("reset_result0", {16'd0, rsp_result[0]}, 32'd0);
        check("reset_result1", {16'd0, rsp_result[1]}, 32'd0);
        check("reset_alu", {12'd0, alu_ctrl, alu_a | alu_b}, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        resetn = 1'b1;

        // Single-requester operations from the table.
        for (int i = 0; i < 5; i++)
            run_op(vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].bp);

        // Both requesters valid continuously from reset.
`ifdef ALU_ARB_FIXED_PRIO_EN
        order_exp[0] = 0; order_exp[1] = 0; order_exp[2] = 0;
`else
        order_exp[0] = 0; order_exp[1] = 1; order_exp[2] = 0;
`endif
        res_exp[0] = 16'h000C; res_exp[1] = 16'h0002;
        @(negedge clk);
        resetn = 1'b0;
        req_ctrl[0] = OP_MUL; req_a[0] = 16'd3; req_b[0] = 16'd4;
        req_ctrl[1] = OP_ADD; req_a[1] = 16'd1; req_b[1] = 16'd1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr_ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
            g = req_ready[1] ? 1 : 0;
            check("rr_grant_order", g, order_exp[k]);
            n = 0;
            @(negedge clk);
            while (!rsp_valid[g] && n < 20) begin
                @(negedge clk); n++;
            end
            check("rr_rsp_valid", {31'd0, rsp_valid[g]}, 32'd1);
            check("rr_result", {16'd0, rsp_result[g]}, {16'd0, res_exp[g]});
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 2'b00;

        // Response back-pressure while the other requester waits.
        @(negedge clk);
        req_ctrl[0] = OP_ADD; req_a[0] = 16'd5; req_b[0] = 16'd6;
        req_valid[0] = 1'b1;
        #1;
        check("bp_req0_ready", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_ctrl[1] = OP_SUB; req_a[1] = 16'd9; req_b[1] = 16'd2;
        req_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk); n++;
        end
        check("bp_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp5_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp5_result", {16'd0, rsp_result[0]}, 32'h000B);
            check("bp5_req1_ready", {31'd0, req_ready[1]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("bp_req1_accept_next", {31'd0, req_ready[1]}, 32'd1);
        check("bp_rsp0_dropped", {31'd0, rsp_valid[0]}, 32'd0);
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[1] && n < 20) begin
            @(negedge clk); n++;
        end
        check("bp_req1_result", {16'd0, rsp_result[1]}, 32'h0007);
        @(negedge clk);
        rsp_ready[1] = 1'b0;

        // Reset for one cycle during EXEC.
        @(negedge clk);
        req_ctrl[0] = OP_ADD; req_a[0] = 16'd2; req_b[0] = 16'd3;
        req_valid[0] = 1'b1;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("mid_exec_state", {30'd0, dbg_state}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mid_reset_state", {30'd0, dbg_state}, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_alu", {12'd0, alu_ctrl, alu_a | alu_b}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid != 2'b00) pulses++;
            @(negedge clk);
        end
        check("mid_reset_no_rsp", pulses, 0);
        check("mid_reset_result0", {16'd0, rsp_result[0]}, 32'd0);
        rsp_ready = 2'b00;
        run_op(0, OP_ADD, 16'd2, 16'd3, 16'h0005, 0);

        // ALU_LATENCY=2: capture three cycles after accept.
        @(negedge clk);
        d2_resetn = 1'b1;
        d2_req0_ctrl = OP_NEG; d2_req0_a = 16'h0001; d2_req0_b = 16'h0000;
        d2_req0_valid = 1'b1;
        d2_rsp0_ready = 1'b1;
        #1;
        check("lat2_ready", {31'd0, d2_req0_ready}, 32'd1);
        @(posedge clk); #1;
        d2_req0_valid = 1'b0;
        n = 0;
        while (!d2_rsp0_valid && n < 20) begin
            @(negedge clk); n++;
            if (n == LAT2 + 1) check("lat2_no_early_capture", {16'd0, d2_rsp0_result}, 32'd0);
        end
        check("lat2_rsp_latency", n, LAT2 + 2);
        check("lat2_result", {16'd0, d2_rsp0_result}, 32'h0000FFFF);
        check("lat2_rsp1_low", {31'd0, d2_rsp1_valid}, 32'd0);
        @(negedge clk);
        check("lat2_idle", {31'd0, d2_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
